inst_fetch_ctrl: RTL
====================

// Module: inst_fetch_ctrl
// PURPOSE
//  Sequences instruction fetch from the 4KB combinational instruction memory (ce/addr/data, word index addr>>2).
//  Owns the PC, drives mem ce/addr, registers the returned word into an IF/ID output stage with valid/ready handshake.
//  Handles decode back-pressure, branch/jump redirects, halt/resume and out-of-range or misaligned fetch faults.
//  Sits between the instruction memory and the decode stage of the MIPS core.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  MEM_BYTES  4096           instruction memory size in bytes; fetch addr >= MEM_BYTES is a fault
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  imem_ce        out  1   instruction memory chip enable
//  imem_addr      out  32  byte address to instruction memory
//  imem_data      in   32  instruction word, valid combinationally in same cycle as imem_addr
//  redirect_valid in   1   branch/jump/exception taken this cycle
//  redirect_pc    in   32  target byte address for redirect
//  halt_req       in   1   stop fetching (level)
//  id_ready       in   1   decode accepts if_inst this cycle
//  if_valid       out  1   if_inst/if_pc hold a valid instruction
//  if_inst        out  32  fetched instruction
//  if_pc          out  32  byte address of if_inst
//  fetch_fault    out  1   sticky: bad fetch address detected
//  fault_pc       out  32  offending address (valid when fetch_fault)
//  fetch_count    out  32  number of instructions handed to decode (wraps)
// BEHAVIOUR
//  Reset (async assert, sync release): state=FETCH, pc=RESET_PC, if_valid=0, if_inst=0, if_pc=0,
//   fetch_fault=0, fault_pc=0, fetch_count=0; imem_ce=0 while rst_n low.
//  imem_addr = pc always; imem_ce = (state==FETCH) && out-stage can load (!if_valid || id_ready).
//  Latency: one cycle from pc to if_valid; sustained 1 instr/cycle when id_ready stays 1.
//  States: FETCH, HALT, FAULT.
//   FETCH: if load allowed: if_inst<=imem_data, if_pc<=pc, if_valid<=1, pc<=pc+4.
//          if_valid && !id_ready: outputs and pc hold, ce=0.
//          if_valid && id_ready && !load: if_valid<=0.
//   halt_req=1 in FETCH -> HALT next cycle; word already in output stage still delivered; no new fetch.
//   HALT: ce=0, pc holds; halt_req=0 -> FETCH. Redirect in HALT updates pc, stays HALT.
//   FAULT: ce=0, if_valid cleared once current word accepted; exit only by reset.
//  Redirect (highest priority, any state except FAULT): pc<=redirect_pc, if_valid<=0 (flush, word dropped,
//   not counted) in same edge; fetch resumes from target next cycle (1 bubble). Beats halt_req and stall.
//  Fault: in FETCH, pc[1:0]!=0 or pc>=MEM_BYTES at load time -> no load, fetch_fault<=1, fault_pc<=pc, state<=FAULT.
//   Redirect to bad target faults on the following fetch attempt, not at redirect.
//  pc+4 is 32-bit modulo; wrap past MEM_BYTES produces a fault, never a silent alias.
//  fetch_count increments on each if_valid && id_ready handshake; 32-bit wrap 0xFFFF_FFFF -> 0.
//  Simultaneous handshake + load: count increments and new word loads same edge.
//  rst_n low mid-operation: immediate return to reset values regardless of state.
// STRUCTURE
//  Shared include cpu_defs.vh: state encodings (FS_FETCH/FS_HALT/FS_FAULT, 2 bits), RESET_PC default,
//   INST_NOP 32'h0000_0000, IMEM_BYTES 4096.
//  Single module; no sub-module warranted. Next-PC mux kept as one always block (redirect > hold > pc+4).
//  Bench instantiates the instruction memory and drives decode/redirect/halt stimulus.
// TESTING
//  Reset, id_ready=1 for 5 cycles -> if_pc 0,4,8,C,10; if_inst 0000f025,241d1000,8f990008,... ; fetch_count=5.
//  id_ready=0 for 3 cycles while if_valid, if_pc=8 -> if_pc/if_inst stable, imem_ce=0, pc held, count unchanged.
//  redirect_valid with redirect_pc=0x20 while id_ready=0 -> next cycle if_valid=0; following cycle if_pc=0x20, if_inst=0c000008.
//  halt_req=1 for 4 cycles then 0 -> pending word delivered once, no fetch during HALT, resume at next sequential pc.
//  redirect_pc=0x1002 -> fetch_fault=1, fault_pc=0x1002, state FAULT, imem_ce=0 until rst_n pulse; redirect_pc=0xFFC then run -> fault_pc=0x1000.
//  Assert rst_n=0 mid-stream asynchronously (between edges) -> outputs at reset values immediately; restart at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction fetch controller.
// The state encoding, the default reset PC and the memory size are all defined here.
package inst_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        FS_FETCH = 2'd0,
        FS_HALT  = 2'd1,
        FS_FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0000;
    localparam int          IMEM_BYTES   = 4096;

    // A fetch address is bad if it is not word aligned or lies past the end of memory.
    function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] limit);
        return (addr[1:0] != 2'b00) || (addr >= limit);
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the combinational instruction memory,
// and holds the fetched word in an IF/ID stage that uses a valid/ready handshake.
//
// state    | meaning
// FS_FETCH | fetch one word per cycle whenever the output stage can take it
// FS_HALT  | fetching paused by halt_req; a pending word still drains
// FS_FAULT | bad fetch address seen; only reset leaves this state
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          MEM_BYTES = IMEM_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_ce,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        fetch_fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic         can_load;
    logic         handshake;
    logic         flush;
    logic         load;
    logic         fault_hit;

    assign can_load  = (state == FS_FETCH) && (!if_valid || id_ready);
    assign handshake = if_valid && id_ready;
    assign flush     = redirect_valid && (state != FS_FAULT);
    assign load      = can_load && !flush && !addr_bad(pc, MEM_LIMIT);
    assign fault_hit = can_load && !flush && addr_bad(pc, MEM_LIMIT);

    // Gate with rst_n so the memory is never enabled while reset is held.
    assign imem_ce   = rst_n && can_load;
    assign imem_addr = pc;

    // Next-PC priority: redirect, then hold, then sequential.
    always_comb begin
        pc_next = pc;
        if (flush) begin
            pc_next = redirect_pc;
        end else if (load) begin
            pc_next = pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FS_FETCH;
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_inst     <= INST_NOP;
            if_pc       <= 32'h0;
            fetch_fault <= 1'b0;
            fault_pc    <= 32'h0;
            fetch_count <= 32'h0;
        end else begin
            pc <= pc_next;

            // A flushed word is dropped, so it does not count as handed over.
            if (handshake && !flush) begin
                fetch_count <= fetch_count + 32'd1;
            end

            if (flush) begin
                if_valid <= 1'b0;
            end else if (load) begin
                if_valid <= 1'b1;
                if_inst  <= imem_data;
                if_pc    <= pc;
            end else if (handshake) begin
                if_valid <= 1'b0;
            end

            if (fault_hit) begin
                fetch_fault <= 1'b1;
                fault_pc    <= pc;
            end

            case (state)
                FS_FETCH: begin
                    if (fault_hit) begin
                        state <= FS_FAULT;
                    end else if (halt_req && !flush) begin
                        state <= FS_HALT;
                    end
                end
                FS_HALT: begin
                    if (!halt_req && !flush) begin
                        state <= FS_FETCH;
                    end
                end
                default: state <= FS_FAULT;
            endcase
        end
    end

endmodule
